alu_booth_multiplier: RTL and testbench

ALU_BOOTH_MULTIPLIER -- requirements
Module: alu_booth_multiplier

---
 rtl/alu_mul_pkg.sv | 23 ++
 rtl/booth_recoder.sv | 43 ++++
 rtl/alu_booth_multiplier.sv | 148 ++++++++++++++
 tb/tb_alu_booth_multiplier.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_pkg.sv
// Shared definitions for the Booth multiplier slice.
//   state_e     : FSM state encoding (IDLE / EXEC / DONE)
//   booth_sel_e : Booth digit selector produced by booth_recoder
//   CNT_W       : step counter width, large enough for WIDTH/STEPS up to 64/65
package alu_mul_pkg;

  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_POS1 = 3'd1,
    SEL_NEG1 = 3'd2,
    SEL_POS2 = 3'd3,
    SEL_NEG2 = 3'd4
  } booth_sel_e;

endpackage

// File: rtl/booth_recoder.sv
// Combinational Booth digit selection.
//   recode_bits : {x[i+1], x[i], x[i-1]} window of the multiplier
//   mcand       : sign/zero-extended multiplicand, AW bits
//   sel         : selected digit (0, +A, -A, +2A, -2A)
//   addend      : the value to add into the accumulator's upper half
// A radix-2 window {x0, x-1} is presented as {x0, x0, x-1}; the radix-4 table
// then yields x-1 - x0, so one table serves both recodings.
module booth_recoder
  import alu_mul_pkg::*;
#(
  parameter int AW = 36
) (
  input  logic [2:0]    recode_bits,
  input  logic [AW-1:0] mcand,
  output booth_sel_e    sel,
  output logic [AW-1:0] addend
);

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sel = SEL_ZERO;
    unique case (recode_bits)
      3'b001, 3'b010: sel = SEL_POS1;
      3'b011:         sel = SEL_POS2;
      3'b100:         sel = SEL_NEG2;
      3'b101, 3'b110: sel = SEL_NEG1;
      default:        sel = SEL_ZERO;
    endcase
  end

  always_comb begin
    addend = '0;
    unique case (sel)
      SEL_POS1: addend = mcand;
      SEL_NEG1: addend = -mcand;
      SEL_POS2: addend = mcand << 1;
      SEL_NEG2: addend = -(mcand << 1);
      default:  addend = '0;
    endcase
  end

endmodule

// File: rtl/alu_booth_multiplier.sv
// Sequential Booth multiplier, signed or unsigned operands.
//   clk, reset_n   : clock, asynchronous active-low reset
//   op_start       : start request (sampled in IDLE only)
//   op_clear       : synchronous abort/clear, wins over op_start
//   op_signed      : 1 = two's complement operands, 0 = unsigned
//   multiplicand   : operand A, multiplier : operand X (latched on start)
//   result         : 2*WIDTH product register (partial value while busy)
//   op_busy/op_done: registered-state decodes of EXEC / DONE
// Build option: define BOOTH_RADIX4_EN for radix-4 modified Booth
// (WIDTH/2+1 steps); otherwise radix-2 Booth (WIDTH+1 steps).
//
// Accumulator layout: {hi[H-1:0], lo[N-1:0]} plus a separate x[-1] bit.
// lo starts as the extended multiplier and is consumed from the bottom while
// product bits shift in from hi. N = STEPS*SHIFT multiplier bits are scanned,
// which covers the extended operand exactly, so the final register holds the
// full product; its low 2*WIDTH bits are the result.
module alu_booth_multiplier
  import alu_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] result,
  output logic               op_busy,
  output logic               op_done
);

`ifdef BOOTH_RADIX4_EN
  localparam int SHIFT = 2;
  localparam int STEPS = WIDTH / 2 + 1;
`else
  localparam int SHIFT = 1;
  localparam int STEPS = WIDTH + 1;
`endif
  // Two guard bits above the extended operand keep +/-2A partial sums in range.
  localparam int H  = WIDTH + 4;
  localparam int N  = STEPS * SHIFT;
  localparam int PW = H + N;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic               xm1_q, xm1_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               signed_q, signed_d;

  logic [H-1:0]        a_ext;
  logic [2:0]          recode_bits;
  booth_sel_e          sel;
  logic [H-1:0]        addend;
  logic [H-1:0]        hi_sum;
  logic signed [PW-1:0] pre_shift;
  logic [PW-1:0]       stepped;

  assign a_ext = {{(H-WIDTH){signed_q & mcand_q[WIDTH-1]}}, mcand_q};

`ifdef BOOTH_RADIX4_EN
  assign recode_bits = {acc_q[1], acc_q[0], xm1_q};
`else
  assign recode_bits = {acc_q[0], acc_q[0], xm1_q};
`endif

  booth_recoder #(.AW(H)) u_recoder (
    .recode_bits (recode_bits),
    .mcand       (a_ext),
    .sel         (sel),
    .addend      (addend)
  );

  // One Booth step: add the selected digit into hi, then shift the whole
  // register right arithmetically so the sign of the partial sum is kept.
  always_comb begin
    hi_sum    = acc_q[PW-1 -: H] + addend;
    pre_shift = {hi_sum, acc_q[N-1:0]};
    stepped   = pre_shift >>> SHIFT;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    xm1_d    = xm1_q;
    mcand_d  = mcand_q;
    signed_d = signed_q;

    unique case (state_q)
      IDLE: begin
        if (op_start) begin
          mcand_d  = multiplicand;
          signed_d = op_signed;
          acc_d    = {{H{1'b0}},
                      {(N-WIDTH){op_signed & multiplier[WIDTH-1]}}, multiplier};
          xm1_d    = 1'b0;
          cnt_d    = '0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        acc_d = stepped;
        xm1_d = acc_q[SHIFT-1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = DONE;
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    // Clear overrides anything decided above, including a same-cycle start.
    if (op_clear) begin
      state_d = IDLE;
      acc_d   = '0;
      xm1_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      xm1_q    <= 1'b0;
      mcand_q  <= '0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      xm1_q    <= xm1_d;
      mcand_q  <= mcand_d;
      signed_q <= signed_d;
    end
  end

  assign result  = acc_q[2*WIDTH-1:0];
  assign op_busy = (state_q == EXEC);
  assign op_done = (state_q == DONE);

endmodule

// File: tb/tb_alu_booth_multiplier.sv
// Directed self-checking bench for alu_booth_multiplier at WIDTH=32.
// Expected products are hand-computed constants, plus a short loop whose
// expectations come from a plain 64-bit multiply of the extended operands.
module tb_alu_booth_multiplier;

  localparam int W = 32;
`ifdef BOOTH_RADIX4_EN
  localparam int STEPS = W / 2 + 1;
`else
  localparam int STEPS = W + 1;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           op_start = 1'b0;
  logic           op_clear = 1'b0;
  logic           op_signed = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [2*W-1:0] result;
  logic           op_busy;
  logic           op_done;

  int errors = 0;
  int checks = 0;

  alu_booth_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .op_signed    (op_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result),
    .op_busy      (op_busy),
    .op_done      (op_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start an operation and wait for op_done. edges counts rising edges from
  // the one that samples op_start up to and including the one that sets
  // op_done. With scramble set, operands, mode and op_start are disturbed
  // every cycle after acceptance.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] x, input logic sgn,
                        input bit scramble, output int edges, output logic busy_seen);
    @(negedge clk);
    multiplicand = a;
    multiplier   = x;
    op_signed    = sgn;
    op_start     = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    op_start  = 1'b0;
    busy_seen = op_busy;
    while (!op_done && edges < 200) begin
      if (scramble) begin
        multiplicand = $urandom;
        multiplier   = $urandom;
        op_signed    = ~op_signed;
        op_start     = ~op_start;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    op_start = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_clear = 1'b0;
  endtask

  initial begin
    int edges;
    logic busy_seen;
    logic [W-1:0] ra, rx;
    logic rs;
    logic [63:0] rexp;

    // Reset state.
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result", result, 64'h0);
    check("reset_busy", {63'b0, op_busy}, 64'h0);
    check("reset_done", {63'b0, op_done}, 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Signed 7 * -3, with latency.
    run_op(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, edges, busy_seen);
    check("s7xm3_busy", {63'b0, busy_seen}, 64'h1);
    check("s7xm3_edges", 64'(edges), 64'(STEPS + 1));
    check("s7xm3_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
    check("s7xm3_done", {63'b0, op_done}, 64'h1);
    do_clear();
    check("clear_result", result, 64'h0);
    check("clear_done", {63'b0, op_done}, 64'h0);

    // All-ones operands, both modes.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, edges, busy_seen);
    check("u_ff_ff", result, 64'hFFFF_FFFE_0000_0001);
    do_clear();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, edges, busy_seen);
    check("s_ff_ff", result, 64'h0000_0000_0000_0001);
    do_clear();

    // Most-negative squared, then DONE must hold against op_start pulses.
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, edges, busy_seen);
    check("s_min_sq", result, 64'h4000_0000_0000_0000);
    for (int i = 0; i < 10; i++) begin
      multiplicand = $urandom;
      multiplier   = $urandom;
      op_start     = i[0];
      @(posedge clk);
      @(negedge clk);
      check("done_hold_result", result, 64'h4000_0000_0000_0000);
      check("done_hold_done", {63'b0, op_done}, 64'h1);
    end
    op_start = 1'b0;
    do_clear();

    // Extra boundary vectors.
    run_op(32'h8000_0000, 32'd2, 1'b0, 1'b0, edges, busy_seen);
    check("u_min_x2", result, 64'h0000_0001_0000_0000);
    do_clear();
    run_op(32'h8000_0000, 32'd2, 1'b1, 1'b0, edges, busy_seen);
    check("s_min_x2", result, 64'hFFFF_FFFF_0000_0000);
    do_clear();
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, edges, busy_seen);
    check("s_max_sq", result, 64'h3FFF_FFFF_0000_0001);
    do_clear();
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, edges, busy_seen);
    check("u_ff_x1", result, 64'h0000_0000_FFFF_FFFF);
    do_clear();
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, edges, busy_seen);
    check("s_m1_x1", result, 64'hFFFF_FFFF_FFFF_FFFF);
    do_clear();

    // op_clear during the fifth EXEC cycle, with a competing op_start.
    @(negedge clk);
    multiplicand = 32'd1000;
    multiplier   = 32'd1000;
    op_signed    = 1'b1;
    op_start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", {63'b0, op_busy}, 64'h1);
    op_clear = 1'b1;
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_clear = 1'b0;
    op_start = 1'b0;
    check("abort_busy", {63'b0, op_busy}, 64'h0);
    check("abort_done", {63'b0, op_done}, 64'h0);
    check("abort_result", result, 64'h0);
    run_op(32'd6, 32'd7, 1'b1, 1'b0, edges, busy_seen);
    check("s6x7", result, 64'd42);
    check("s6x7_edges", 64'(edges), 64'(STEPS + 1));
    do_clear();

    // Asynchronous reset in the middle of EXEC.
    @(negedge clk);
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h0000_FFFF;
    op_signed    = 1'b0;
    op_start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_result", result, 64'h0);
    check("rst_mid_busy", {63'b0, op_busy}, 64'h0);
    check("rst_mid_done", {63'b0, op_done}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_after_result", result, 64'h0);
    check("rst_after_busy", {63'b0, op_busy}, 64'h0);

    // Operands and op_start disturbed every cycle while busy.
    run_op(32'hFFFF_FFFE, 32'd5, 1'b1, 1'b1, edges, busy_seen);
    check("scramble_result", result, 64'hFFFF_FFFF_FFFF_FFF6);
    check("scramble_edges", 64'(edges), 64'(STEPS + 1));
    do_clear();

    // Short random sweep against a 64-bit reference multiply.
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rx = $urandom;
      rs = 1'($urandom_range(0, 1));
      rexp = rs ? ({{32{ra[31]}}, ra} * {{32{rx[31]}}, rx})
                : ({32'b0, ra} * {32'b0, rx});
      run_op(ra, rx, rs, 1'b0, edges, busy_seen);
      check("random", result, rexp);
      do_clear();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
